// File: rtl/fprint_cmd_tx.sv
// Fingerprint command transmitter.
// Queues task and CRC commands from the core's fingerprint logic.
// Drops commands that are illegal against a local shadow of per-task state.
// Issues each remaining command as one Avalon-MM write to the comparator.
module fprint_cmd_tx #(
    parameter int         DATA_W         = 32,
    parameter int         ADDR_W         = 8,
    parameter int         KEY_W          = 4,
    parameter int         FIFO_DEPTH     = 4,
    parameter logic [3:0] CS_OFFSET      = 4'h0,
    parameter logic [3:0] CRC_OFFSET     = 4'h4,
    parameter logic [3:0] PAUSE_OFFSET   = 4'h8,
    parameter logic [3:0] UNPAUSE_OFFSET = 4'hC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        core_id,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [KEY_W-1:0]  cmd_task,
    input  logic [DATA_W-1:0] cmd_crc,
    output logic [ADDR_W-1:0] avm_address,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_write,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic [7:0]        err_count,
    output logic              task_active,
    output logic [KEY_W-1:0]  current_task
);

    localparam int NUM_TASKS = 1 << KEY_W;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);

    localparam logic [2:0] OP_CHECKOUT = 3'd0;
    localparam logic [2:0] OP_CHECKIN  = 3'd1;
    localparam logic [2:0] OP_PAUSE    = 3'd2;
    localparam logic [2:0] OP_UNPAUSE  = 3'd3;
    localparam logic [2:0] OP_CRC      = 3'd4;

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_e;

    state_e state_q, state_d;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [2:0]        fifo_op_q   [FIFO_DEPTH];
    logic [2:0]        fifo_op_d   [FIFO_DEPTH];
    logic [KEY_W-1:0]  fifo_task_q [FIFO_DEPTH];
    logic [KEY_W-1:0]  fifo_task_d [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_crc_q  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_crc_d  [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    wr_vis_q;
    logic              ready_q, ready_d;

    // Bus-side and shadow registers
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic [2:0]           cur_op_q, cur_op_d;
    logic [KEY_W-1:0]     cur_task_q, cur_task_d;
    logic [7:0]           err_q, err_d;
    logic [NUM_TASKS-1:0] checked_out_q, checked_out_d;
    logic [NUM_TASKS-1:0] paused_q, paused_d;
    logic                 active_q, active_d;
    logic [KEY_W-1:0]     current_q, current_d;

    logic              fifo_empty;
    logic              head_avail;
    logic              push;
    logic              full_next;
    logic [2:0]        head_op;
    logic [KEY_W-1:0]  head_task;
    logic [DATA_W-1:0] head_crc;
    logic              head_legal;
    logic [3:0]        head_offset;
    logic [DATA_W-1:0] head_data;

    // The read side sees a pushed entry one cycle after it is written
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign head_avail = (wr_vis_q != rd_ptr_q);
    assign push       = cmd_valid & ready_q;
    assign head_op    = fifo_op_q[rd_ptr_q[PTR_W-1:0]];
    assign head_task  = fifo_task_q[rd_ptr_q[PTR_W-1:0]];
    assign head_crc   = fifo_crc_q[rd_ptr_q[PTR_W-1:0]];

    assign cmd_ready     = ready_q;
    assign avm_address   = addr_q;
    assign avm_writedata = wdata_q;
    assign avm_write     = write_q;
    assign busy          = ~fifo_empty | (state_q == S_ISSUE);
    assign err_count     = err_q;
    assign task_active   = active_q;
    assign current_task  = current_q;

    // Decode the FIFO head: legality against shadow state, register offset and payload
    always_comb begin
        head_legal  = 1'b0;
        head_offset = CS_OFFSET;
        head_data   = '0;
        case (head_op)
            OP_CHECKOUT: begin
                head_legal              = ~checked_out_q[head_task];
                head_offset             = CS_OFFSET;
                head_data[KEY_W-1:0]    = head_task;
                head_data[KEY_W]        = 1'b1;
            end
            OP_CHECKIN: begin
                head_legal              = checked_out_q[head_task];
                head_offset             = CS_OFFSET;
                head_data[KEY_W-1:0]    = head_task;
            end
            OP_PAUSE: begin
                head_legal              = checked_out_q[head_task] & ~paused_q[head_task];
                head_offset             = PAUSE_OFFSET;
                head_data[KEY_W-1:0]    = head_task;
            end
            OP_UNPAUSE: begin
                head_legal              = paused_q[head_task];
                head_offset             = UNPAUSE_OFFSET;
                head_data[KEY_W-1:0]    = head_task;
            end
            OP_CRC: begin
                head_legal  = active_q & checked_out_q[current_q] & ~paused_q[current_q];
                head_offset = CRC_OFFSET;
                head_data   = head_crc;
            end
            default: begin
                head_legal  = 1'b0;
            end
        endcase
    end

    // Next-state logic: FIFO push/pop, issue FSM, error counting and shadow updates
    always_comb begin
        state_d       = state_q;
        fifo_op_d     = fifo_op_q;
        fifo_task_d   = fifo_task_q;
        fifo_crc_d    = fifo_crc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        write_d       = write_q;
        cur_op_d      = cur_op_q;
        cur_task_d    = cur_task_q;
        err_d         = err_q;
        checked_out_d = checked_out_q;
        paused_d      = paused_q;
        active_d      = active_q;
        current_d     = current_q;

        if (push) begin
            fifo_op_d[wr_ptr_q[PTR_W-1:0]]   = cmd_op;
            fifo_task_d[wr_ptr_q[PTR_W-1:0]] = cmd_task;
            fifo_crc_d[wr_ptr_q[PTR_W-1:0]]  = cmd_crc;
            wr_ptr_d                         = wr_ptr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (head_avail) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (head_legal) begin
                        addr_d      = '0;
                        addr_d[7:4] = core_id;
                        addr_d[3:0] = head_offset;
                        wdata_d     = head_data;
                        write_d     = 1'b1;
                        cur_op_d    = head_op;
                        cur_task_d  = head_task;
                        state_d     = S_ISSUE;
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (!avm_waitrequest) begin
                    write_d = 1'b0;
                    state_d = S_IDLE;
                    case (cur_op_q)
                        OP_CHECKOUT: begin
                            checked_out_d[cur_task_q] = 1'b1;
                            current_d                 = cur_task_q;
                            active_d                  = 1'b1;
                        end
                        OP_CHECKIN: begin
                            checked_out_d[cur_task_q] = 1'b0;
                            paused_d[cur_task_q]      = 1'b0;
                            if (cur_task_q == current_q) begin
                                active_d = 1'b0;
                            end
                        end
                        OP_PAUSE: begin
                            paused_d[cur_task_q] = 1'b1;
                        end
                        OP_UNPAUSE: begin
                            paused_d[cur_task_q] = 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        full_next = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                    (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
        ready_d   = ~full_next;
    end

    // State registers; reset abandons any outstanding write immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_op_q[i]   <= '0;
                fifo_task_q[i] <= '0;
                fifo_crc_q[i]  <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wr_vis_q      <= '0;
            ready_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            cur_op_q      <= '0;
            cur_task_q    <= '0;
            err_q         <= '0;
            checked_out_q <= '0;
            paused_q      <= '0;
            active_q      <= 1'b0;
            current_q     <= '0;
        end else begin
            state_q       <= state_d;
            fifo_op_q     <= fifo_op_d;
            fifo_task_q   <= fifo_task_d;
            fifo_crc_q    <= fifo_crc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_vis_q      <= wr_ptr_q;
            ready_q       <= ready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            write_q       <= write_d;
            cur_op_q      <= cur_op_d;
            cur_task_q    <= cur_task_d;
            err_q         <= err_d;
            checked_out_q <= checked_out_d;
            paused_q      <= paused_d;
            active_q      <= active_d;
            current_q     <= current_d;
        end
    end

endmodule

// File: tb/tb_fprint_cmd_tx.sv
// Testbench for fprint_cmd_tx: a shadow-state model predicts each write at
// drive time into a scoreboard queue; a bus monitor pops and compares writes.
module tb_fprint_cmd_tx;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int KEY_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [3:0]        core_id = 4'd2;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = 3'd0;
    logic [KEY_W-1:0]  cmd_task = '0;
    logic [DATA_W-1:0] cmd_crc = '0;
    logic [ADDR_W-1:0] avm_address;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_write;
    logic              avm_waitrequest = 1'b0;
    logic              busy;
    logic [7:0]        err_count;
    logic              task_active;
    logic [KEY_W-1:0]  current_task;

    fprint_cmd_tx dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .core_id         (core_id),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_task        (cmd_task),
        .cmd_crc         (cmd_crc),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_write       (avm_write),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .err_count       (err_count),
        .task_active     (task_active),
        .current_task    (current_task)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t sb_q[$];
    wr_t sb_head;

    int check_count = 0;
    int error_count = 0;
    int completions = 0;
    int high_cycles = 0;
    int last_high_cycles = 0;
    int idle_run = 0;
    int last_gap = 0;

    logic              mon_en = 1'b0;
    logic              prev_write = 1'b0;
    logic              prev_wait = 1'b0;
    logic              prev_done = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;

    // Reference shadow state of the comparator's task view
    logic [15:0] m_checked = '0;
    logic [15:0] m_paused = '0;
    logic        m_active = 1'b0;
    logic [3:0]  m_cur = '0;
    int          exp_err = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Predict the outcome of one command and push the expected write, if any
    task automatic modelCommand(input logic [2:0] op, input logic [3:0] t, input logic [31:0] crc);
        logic        legal;
        logic [3:0]  off;
        logic [31:0] data;
        legal = 1'b0;
        off   = 4'h0;
        data  = 32'd0;
        case (op)
            3'd0: begin
                legal = !m_checked[t];
                off   = 4'h0;
                data  = {27'd0, 1'b1, t};
                if (legal) begin
                    m_checked[t] = 1'b1;
                    m_cur        = t;
                    m_active     = 1'b1;
                end
            end
            3'd1: begin
                legal = m_checked[t];
                off   = 4'h0;
                data  = {28'd0, t};
                if (legal) begin
                    m_checked[t] = 1'b0;
                    m_paused[t]  = 1'b0;
                    if (t == m_cur) m_active = 1'b0;
                end
            end
            3'd2: begin
                legal = m_checked[t] && !m_paused[t];
                off   = 4'h8;
                data  = {28'd0, t};
                if (legal) m_paused[t] = 1'b1;
            end
            3'd3: begin
                legal = m_paused[t];
                off   = 4'hC;
                data  = {28'd0, t};
                if (legal) m_paused[t] = 1'b0;
            end
            3'd4: begin
                legal = m_active && m_checked[m_cur] && !m_paused[m_cur];
                off   = 4'h4;
                data  = crc;
            end
            default: legal = 1'b0;
        endcase
        if (legal) sb_q.push_back({core_id, off, data});
        else if (exp_err < 255) exp_err++;
    endtask

    // Present one command and hold it until accepted (called just after a rising edge)
    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] t, input logic [31:0] crc);
        int waited;
        waited    = 0;
        cmd_op    = op;
        cmd_task  = t;
        cmd_crc   = crc;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checkOutput("pushTimeout", cmd_ready, 1);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end else begin
            modelCommand(op, t, crc);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    // Wait, bounded, until the block has drained and gone idle
    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idleBusy", busy, 0);
        @(posedge clk); #1;
    endtask

    // Assert reset, clear the model and scoreboard, then release
    task automatic resetDut();
        mon_en          = 1'b0;
        reset_n         = 1'b0;
        cmd_valid       = 1'b0;
        avm_waitrequest = 1'b0;
        sb_q.delete();
        m_checked = '0;
        m_paused  = '0;
        m_active  = 1'b0;
        m_cur     = '0;
        exp_err   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    // Bus monitor: hold stability, gap after completion, and scoreboard compare
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (prev_done) checkOutput("gapAfterWrite", avm_write, 0);
            if (prev_write && prev_wait) begin
                checkOutput("holdWrite", avm_write, 1);
                checkOutput("holdAddr", avm_address, prev_addr);
                checkOutput("holdData", avm_writedata, prev_data);
            end
            if (avm_write && !prev_write) last_gap = idle_run;
            if (avm_write) begin
                idle_run = 0;
                high_cycles++;
            end else begin
                idle_run++;
            end
            if (avm_write && !avm_waitrequest) begin
                completions++;
                last_high_cycles = high_cycles;
                high_cycles = 0;
                if (sb_q.size() == 0) begin
                    checkOutput("unexpectedWrite", sb_q.size(), 1);
                end else begin
                    sb_head = sb_q.pop_front();
                    checkOutput("writeAddr", avm_address, sb_head.addr);
                    checkOutput("writeData", avm_writedata, sb_head.data);
                end
            end
            prev_write = avm_write;
            prev_wait  = avm_waitrequest;
            prev_addr  = avm_address;
            prev_data  = avm_writedata;
            prev_done  = avm_write && !avm_waitrequest;
        end else begin
            prev_write  = 1'b0;
            prev_wait   = 1'b0;
            prev_done   = 1'b0;
            high_cycles = 0;
            idle_run    = 0;
        end
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_comp;
        int accepted;
        int n;
        logic ready6;

        // Reset values, and cmd_ready rising on the first clock after release
        #2;
        checkOutput("rstWrite", avm_write, 0);
        checkOutput("rstAddr", avm_address, 0);
        checkOutput("rstData", avm_writedata, 0);
        checkOutput("rstReady", cmd_ready, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstErr", err_count, 0);
        checkOutput("rstActive", task_active, 0);
        checkOutput("rstCurrent", current_task, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("readyBeforeClock", cmd_ready, 0);
        @(posedge clk); #1;
        checkOutput("readyAfterClock", cmd_ready, 1);
        mon_en = 1'b1;

        // Checkout 3 with a 3-cycle stall
        $display("[TB] checkout with waitrequest stall");
        avm_waitrequest = 1'b1;
        start_comp = completions;
        applyStimulus(3'd0, 4'd3, 32'd0);
        n = 0;
        @(negedge clk);
        while (!avm_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stallWriteSeen", avm_write, 1);
        repeat (3) @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
        waitIdle();
        checkOutput("stallHighCycles", last_high_cycles, 4);
        checkOutput("stallCompletions", completions - start_comp, 1);
        checkOutput("activeAfterCheckout", task_active, 1);
        checkOutput("currentAfterCheckout", current_task, 3);

        // CRC after checkout: two-cycle acceptance-to-write latency
        $display("[TB] crc latency");
        applyStimulus(3'd4, 4'd0, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("latencyCycle0", avm_write, 0);
        @(negedge clk);
        checkOutput("latencyCycle1", avm_write, 0);
        @(negedge clk);
        checkOutput("latencyCycle2", avm_write, 1);
        waitIdle();
        checkOutput("crcQueueEmpty", sb_q.size(), 0);

        // Illegal commands after reset are dropped and counted
        $display("[TB] illegal commands");
        resetDut();
        start_comp = completions;
        applyStimulus(3'd4, 4'd0, 32'h1);
        applyStimulus(3'd1, 4'd5, 32'd0);
        waitIdle();
        checkOutput("illegalNoWrite", completions - start_comp, 0);
        checkOutput("illegalErr", err_count, exp_err);
        checkOutput("illegalErrTwo", err_count, 2);

        // Pause/unpause sequence with one illegal crc; also a reserved op
        $display("[TB] pause sequence");
        resetDut();
        applyStimulus(3'd0, 4'd1, 32'd0);
        applyStimulus(3'd2, 4'd1, 32'd0);
        applyStimulus(3'd4, 4'd0, 32'hCAFE0001);
        applyStimulus(3'd3, 4'd1, 32'd0);
        applyStimulus(3'd4, 4'd0, 32'hCAFE0002);
        waitIdle();
        checkOutput("pauseQueueEmpty", sb_q.size(), 0);
        checkOutput("pauseErr", err_count, exp_err);
        applyStimulus(3'd6, 4'd2, 32'd0);
        waitIdle();
        checkOutput("reservedErr", err_count, exp_err);

        // FIFO fill while the slave stalls, then drain
        $display("[TB] fifo fill and drain");
        resetDut();
        avm_waitrequest = 1'b1;
        start_comp = completions;
        accepted = 0;
        ready6 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_op    = 3'd0;
            cmd_task  = 4'(8 + i);
            cmd_crc   = 32'd0;
            cmd_valid = 1'b1;
            @(negedge clk);
            if (i == 5) ready6 = cmd_ready;
            if (cmd_ready) begin
                accepted++;
                modelCommand(3'd0, 4'(8 + i), 32'd0);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        checkOutput("fillAccepted", accepted, 5);
        checkOutput("fillReady6", ready6, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("fillStillReadyLow", cmd_ready, 0);
        avm_waitrequest = 1'b0;
        waitIdle();
        checkOutput("drainCompletions", completions - start_comp, 5);
        checkOutput("drainGap", last_gap, 1);
        checkOutput("drainQueueEmpty", sb_q.size(), 0);

        // Reset asserted mid-write, then normal operation resumes
        $display("[TB] reset during issue");
        resetDut();
        avm_waitrequest = 1'b1;
        applyStimulus(3'd0, 4'd2, 32'd0);
        applyStimulus(3'd9 - 3'd9, 4'd2, 32'd0);
        n = 0;
        @(negedge clk);
        while (!avm_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("issueWriteSeen", avm_write, 1);
        @(posedge clk); #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        checkOutput("midRstWrite", avm_write, 0);
        checkOutput("midRstErr", err_count, 0);
        checkOutput("midRstActive", task_active, 0);
        checkOutput("midRstBusy", busy, 0);
        resetDut();
        applyStimulus(3'd0, 4'd7, 32'd0);
        waitIdle();
        checkOutput("postRstActive", task_active, 1);
        checkOutput("postRstCurrent", current_task, 7);
        checkOutput("postRstQueueEmpty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/fprint_cmd_tx.md
Name: fprint_cmd_tx

Overview:
Core-side fingerprint command transmitter. It is the initiator for the comparator's state-register slave port.
- Accepts task checkout, checkin, pause and unpause commands, plus CRC results, from the core's fingerprint logic.
- Queues them in a small FIFO.
- Issues each one as a single Avalon-MM master write, with the core ID encoded in address bits [7:4].
- Keeps a shadow of per-task state so that illegal commands are dropped locally instead of corrupting comparator state.

Parameters:
- DATA_W, 32, writedata and CRC width.
- ADDR_W, 8, avm_address width (minimum 8).
- KEY_W, 4, task ID width; the block tracks 2^KEY_W tasks.
- FIFO_DEPTH, 4, command FIFO entries (power of 2).
- CS_OFFSET, 4'h0, checkout/checkin register offset.
- CRC_OFFSET, 4'h4, CRC register offset.
- PAUSE_OFFSET, 4'h8, pause register offset.
- UNPAUSE_OFFSET, 4'hC, unpause register offset.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- core_id  in  4  this core's ID; static after reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  3  0=checkout, 1=checkin, 2=pause, 3=unpause, 4=crc; 5-7 reserved.
- cmd_task  in  KEY_W  task ID; ignored for crc.
- cmd_crc  in  DATA_W  CRC value; used only for crc.
- avm_address  out  ADDR_W  write address.
- avm_writedata  out  DATA_W  write data.
- avm_write  out  1  write strobe.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  FIFO non-empty or a write is outstanding.
- err_count  out  8  count of dropped commands, saturating.
- task_active  out  1  a current task is valid.
- current_task  out  KEY_W  last checked-out task ID.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Outputs: avm_write=0, avm_address=0, avm_writedata=0, cmd_ready=0, busy=0, err_count=0, task_active=0, current_task=0.
  - FIFO is emptied; checked_out and paused bitmaps are cleared; FSM goes to IDLE.
  - cmd_ready goes to 1 on the first clock after reset_n rises.
- Push side:
  - A command is accepted when cmd_valid & cmd_ready.
  - cmd_ready = ~fifo_full; there is no bypass, so a push while full is ignored.
  - A push and a pop in the same cycle are both honoured.
- Address encoding: avm_address = {zeros, core_id, offset[3:0]}.
- Writedata encoding:
  - checkout: {zeros, 1'b1, task}.
  - checkin: {zeros, 1'b0, task}.
  - pause and unpause: {zeros, task}.
  - crc: cmd_crc.
- FSM state IDLE:
  - If the FIFO is non-empty, pop the head and evaluate its legality against the shadow state.
  - If legal: register address and data, set avm_write=1 on the next edge, go to ISSUE.
  - If illegal or reserved op: no write; err_count+1, saturating at 255; stay in IDLE, so the next entry can pop on the next cycle.
- Legality rules:
  - checkout: ~checked_out[t].
  - checkin: checked_out[t].
  - pause: checked_out[t] & ~paused[t].
  - unpause: paused[t].
  - crc: task_active & checked_out[current_task] & ~paused[current_task].
- FSM state ISSUE:
  - avm_address, avm_writedata and avm_write are held stable while avm_waitrequest=1, for any duration.
  - Completion is the cycle with avm_write=1 & avm_waitrequest=0.
  - On completion, the next edge sets avm_write=0, applies the shadow update and returns to IDLE.
  - Consecutive writes therefore always have at least one idle cycle between them.
- Shadow updates, applied at completion only:
  - checkout: checked_out[t]=1, current_task=t, task_active=1.
  - checkin: checked_out[t]=0, paused[t]=0; if t==current_task then task_active=0.
  - pause: paused[t]=1.
  - unpause: paused[t]=0.
  - crc: no shadow change.
- Latency: a command accepted on edge N (FIFO empty, FSM idle) raises avm_write after edge N+2.
- Only one write is outstanding at a time; the FIFO keeps accepting commands during ISSUE.
- busy = ~fifo_empty | (state==ISSUE).
- Reset asserted during ISSUE: avm_write drops immediately and the write is abandoned. Comparator resynchronisation is the system's responsibility.
- FIFO read and write pointers wrap modulo FIFO_DEPTH; full/empty are decided using an extra pointer bit.

Test Plan:
- core_id=2, checkout task 3, avm_waitrequest high for 3 cycles → avm_address=8'h20, avm_writedata=32'h13; these and avm_write stay stable for 4 cycles; exactly one completion; then task_active=1, current_task=3.
- After that checkout, crc 32'hDEADBEEF → avm_address=8'h24, avm_writedata=32'hDEADBEEF; avm_write rises 2 cycles after acceptance.
- After reset, crc 32'h1, then checkin task 5 → no avm_write at all; err_count=2; busy returns to 0.
- Checkout 1, pause 1, crc, unpause 1, crc → writes at 8'h20, 8'h28, 8'h2C, 8'h24 in that order, with pause and unpause writedata = 1; err_count=1.
- avm_waitrequest held at 1, 6 back-to-back pushes → 5 accepted (1 in ISSUE, 4 queued); cmd_ready=0 on the 6th; releasing waitrequest drains all 5 with a 1-cycle gap between writes.
- reset_n low mid-ISSUE → avm_write=0, err_count=0, task_active=0, busy=0 in the same cycle; after release, a new checkout issues normally.
